// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch constants and PC alignment helper
package cpu_pkg;
  localparam int ILEN = 32;
  localparam logic [63:0] RESET_PC_DEF = '0;
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: flushable synchronous FIFO, head presented from registered storage
module sync_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [PW:0] r_wptr, r_rptr;
  // storage and pointers; flush only rewinds pointers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr[PW-1:0]] <= i_wdata;
        r_wptr <= r_wptr + ONE;
      end
      if (i_pop) r_rptr <= r_rptr + ONE;
    end
  assign o_count = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[PW-1:0]];
endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: credit-based instruction prefetcher with redirect drop counting
module ifetch_prefetch import cpu_pkg::*; #(
  parameter int XLEN = ILEN,
  parameter int AW = 14,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [AW-1:0]   imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4,
  output logic            misalign_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE = 1;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_outst, w_q_cnt, w_outst_nxt;
  logic [CW:0] w_credit;
  logic [XLEN-1:0] w_rsp_pc;
  logic w_fire, w_push, w_pop;
  // outstanding requests are exactly the PCs waiting for their response
  sync_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_fifo (
    .clk(clk), .rst(rst), .i_flush(1'b0), .i_push(w_fire), .i_wdata(r_pc),
    .i_pop(imem_rsp_valid), .o_rdata(w_rsp_pc), .o_count(w_outst)
  );
  sync_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_inst_q (
    .clk(clk), .rst(rst), .i_flush(redirect_valid), .i_push(w_push),
    .i_wdata({imem_rsp_data, w_rsp_pc}), .i_pop(w_pop),
    .o_rdata({inst_data, inst_pc}), .o_count(w_q_cnt)
  );
  assign w_credit = (CW+1)'(w_outst) + (CW+1)'(w_q_cnt);
  assign imem_req_valid = !rst && !redirect_valid && w_credit < (CW+1)'(DEPTH);
  assign imem_req_addr = r_pc[AW+1:2];
  assign w_fire = imem_req_valid && imem_req_ready;
  assign w_push = imem_rsp_valid && r_drop == '0 && !redirect_valid;
  assign w_pop = inst_valid && inst_ready && !redirect_valid;
  assign w_outst_nxt = w_outst + CW'(w_fire) - CW'(imem_rsp_valid);
  assign inst_valid = w_q_cnt != '0;
  assign inst_pc_plus4 = inst_pc + XLEN'(4);
  assign misalign_err = !rst && redirect_valid && redirect_pc[1:0] != 2'b00;
  // fetch PC and count of stale responses still in flight after a redirect
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc <= RESET_PC;
      r_drop <= '0;
    end else if (redirect_valid) begin
      r_pc <= XLEN'(align_pc(64'(redirect_pc)));
      r_drop <= w_outst_nxt;
    end else begin
      if (w_fire) r_pc <= r_pc + XLEN'(4);
      if (imem_rsp_valid && r_drop != '0) r_drop <= r_drop - ONE;
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: random memory/decode traffic checked against a program-order model
module tb_ifetch_prefetch;
  localparam int XLEN = 32;
  localparam int AW = 14;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic inst_valid, inst_ready, misalign_err;
  logic [AW-1:0] imem_req_addr;
  logic [31:0] imem_rsp_data, redirect_pc, inst_data, inst_pc, inst_pc_plus4;
  ifetch_prefetch #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc_plus4(inst_pc_plus4), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_due = 0, pops = 0, fires = 0;
  int lat_lo = 1, lat_hi = 1, p_rdy = 100, p_irdy = 100, p_redir = 0;
  logic [AW-1:0] pa[$];
  int pd[$];
  logic [31:0] exp_pc, exp_fetch, force_tgt, last_ipc;
  logic [AW-1:0] last_addr;
  logic force_redir = 0, prev_redir = 0, last_iv, last_rsp, last_mis, last_rv;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h5A5A;
  endfunction
  function automatic logic [31:0] pick_tgt();
    return ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : 32'($urandom_range(4095));
  endfunction
  task automatic step();
    logic [31:0] np;
    logic fire, pop;
    int due;
    imem_req_ready = $urandom_range(99) < p_rdy;
    inst_ready = $urandom_range(99) < p_irdy;
    redirect_valid = force_redir || $urandom_range(999) < p_redir;
    redirect_pc = force_redir ? force_tgt : pick_tgt();
    imem_rsp_valid = pa.size() != 0 && pd[0] <= cyc;
    imem_rsp_data = imem_rsp_valid ? memf(pa[0]) : $urandom;
    #1;
    check("misalign", misalign_err, redirect_valid && redirect_pc[1:0] != 2'b00);
    if (redirect_valid) check("req_suppress", imem_req_valid, 0);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_fetch[AW+1:2]);
    if (prev_redir) check("inv_after_redir", inst_valid, 0);
    if (inst_valid) begin
      np = exp_pc + 32'd4;
      check("inst_pc", inst_pc, exp_pc);
      check("inst_data", inst_data, memf(exp_pc[AW+1:2]));
      check("pc_plus4", inst_pc_plus4, np);
    end
    last_iv = inst_valid; last_ipc = inst_pc; last_rsp = imem_rsp_valid;
    last_mis = misalign_err; last_rv = imem_req_valid; last_addr = imem_req_addr;
    fire = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready && !redirect_valid;
    if (imem_rsp_valid) begin
      void'(pa.pop_front());
      void'(pd.pop_front());
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due < last_due) due = last_due;
      last_due = due;
      pa.push_back(imem_req_addr);
      pd.push_back(due);
      exp_fetch = exp_fetch + 32'd4;
      fires++;
    end
    if (pop) begin
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
      exp_fetch = exp_pc;
    end
    check("credit", pa.size() <= DEPTH, 1);
    prev_redir = redirect_valid;
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2;
    rst = 1;
    imem_req_ready = 0; inst_ready = 0; imem_rsp_valid = 0; redirect_valid = 0;
    redirect_pc = 0; imem_rsp_data = 0;
    pa.delete(); pd.delete();
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_plus4", inst_pc_plus4, 4);
    repeat (2) @(negedge clk);
    rst = 0;
    exp_pc = RESET_PC; exp_fetch = RESET_PC; prev_redir = 0;
  endtask
  task automatic redirect_to(logic [31:0] t);
    force_tgt = t; force_redir = 1;
    step();
    force_redir = 0;
  endtask
  task automatic wait_inst(logic [31:0] e);
    logic seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (last_iv) begin
        seen = 1;
        check("first_pc", last_ipc, e);
      end
    end
    check("wait_inst_seen", seen, 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int p0, f0;
    do_reset();
    p0 = pops;
    repeat (6) step();
    check("stream_pops", pops - p0, 4);
    check("stream_pc", exp_pc, 16);
    do_reset();
    p_irdy = 0; f0 = fires;
    repeat (10) step();
    check("stall_reqs", fires - f0, DEPTH);
    check("stall_req_valid", last_rv, 0);
    p_irdy = 100; p0 = pops;
    repeat (8) step();
    check("stall_release", pops - p0 >= 5, 1);
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && pa.size() != 3; i++) step();
    check("outst3", pa.size(), 3);
    redirect_to(32'h100);
    wait_inst(32'h100);
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (4) step();
    redirect_to(32'h102);
    check("mis_pulse", last_mis, 1);
    step();
    check("mis_once", last_mis, 0);
    wait_inst(32'h100);
    do_reset();
    repeat (5) step();
    check("pre_pop_push", last_iv && last_rsp, 1);
    redirect_to(32'h200);
    wait_inst(32'h200);
    repeat (3) step();
    check("rst_pre_valid", last_iv, 1);
    do_reset();
    step();
    check("rst_first_req", last_rv, 1);
    check("rst_first_addr", last_addr, RESET_PC[AW+1:2]);
    for (int r = 0; r < 6; r++) begin
      lat_lo = 1; lat_hi = 5; p_rdy = 70; p_irdy = 60; p_redir = 40;
      repeat (500) step();
      p_rdy = 100; p_irdy = 100; p_redir = 0;
      p0 = pops;
      repeat (30) step();
      check("drain_progress", pops - p0 >= 5, 1);
      do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
